mem_stage: RTL and testbench

- Memory stage of the 5-stage pipeline. Consumes the EX/MEM pipeline outputs (MEMwreg, MEMm2reg, MEMwmem, MEMwn, MEMaluResult, MEMdi).
- Performs loads/stores over a variable-latency req/ack data-memory port and stalls the pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register feeding write-back.
- Detects misaligned word addresses and bus timeouts; either error squashes the register write.

---
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: drives a req/ack data-memory port, stalls the pipeline while an
// access is outstanding, and holds the MEM/WB pipeline register.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        MEMwreg,
    input  logic        MEMm2reg,
    input  logic        MEMwmem,
    input  logic [4:0]  MEMwn,
    input  logic [31:0] MEMaluResult,
    input  logic [31:0] MEMdi,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_stall,
    output logic        WBwreg,
    output logic        WBm2reg,
    output logic [4:0]  WBwn,
    output logic [31:0] WBaluResult,
    output logic [31:0] WBmo,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        to_q, to_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wreg_q, wreg_d;
    logic        m2reg_q, m2reg_d;
    logic [4:0]  wn_q, wn_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mo_q, mo_d;
    logic        emis_q, emis_d;
    logic        eto_q, eto_d;
    logic        req_c, stall_c;
    logic        access, misaligned;

    assign access     = MEMm2reg | MEMwmem;
    assign misaligned = access & (MEMaluResult[1:0] != 2'b00);

    assign dm_addr  = MEMaluResult;
    assign dm_wdata = MEMdi;
    assign dm_we    = MEMwmem;

    // Gated by clrn so both drop the instant reset asserts, even with an access on the inputs.
    assign dm_req    = clrn & req_c;
    assign mem_stall = clrn & stall_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        rdata_d = rdata_q;
        wreg_d  = 1'b0;
        m2reg_d = 1'b0;
        wn_d    = MEMwn;
        alu_d   = MEMaluResult;
        mo_d    = 32'd0;
        emis_d  = 1'b0;
        eto_d   = 1'b0;
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!access) begin
                    wreg_d  = MEMwreg;
                    m2reg_d = MEMm2reg;
                end else if (misaligned) begin
                    emis_d = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            S_WAIT: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                // An ack on the final allowed cycle still completes the access cleanly.
                if (dm_ack) begin
                    rdata_d = dm_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wreg_d  = MEMwreg & ~to_q;
                m2reg_d = MEMm2reg;
                mo_d    = MEMwmem ? 32'd0 : rdata_q;
                eto_d   = to_q;
                to_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            to_q    <= 1'b0;
            rdata_q <= 32'd0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wn_q    <= 5'd0;
            alu_q   <= 32'd0;
            mo_q    <= 32'd0;
            emis_q  <= 1'b0;
            eto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            rdata_q <= rdata_d;
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            wn_q    <= wn_d;
            alu_q   <= alu_d;
            mo_q    <= mo_d;
            emis_q  <= emis_d;
            eto_q   <= eto_d;
        end
    end

    assign WBwreg       = wreg_q;
    assign WBm2reg      = m2reg_q;
    assign WBwn         = wn_q;
    assign WBaluResult  = alu_q;
    assign WBmo         = mo_q;
    assign err_misalign = emis_q;
    assign err_timeout  = eto_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: single-cycle vector table plus multi-cycle access sequences,
// with MEM/WB results checked against a queue of expected records.
module tb_mem_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        clrn;
    logic        MEMwreg, MEMm2reg, MEMwmem;
    logic [4:0]  MEMwn;
    logic [31:0] MEMaluResult, MEMdi;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack;
    logic        mem_stall;
    logic        WBwreg, WBm2reg;
    logic [4:0]  WBwn;
    logic [31:0] WBaluResult, WBmo;
    logic        err_misalign, err_timeout;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .clrn(clrn),
        .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg), .MEMwmem(MEMwmem),
        .MEMwn(MEMwn), .MEMaluResult(MEMaluResult), .MEMdi(MEMdi),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_stall(mem_stall),
        .WBwreg(WBwreg), .WBm2reg(WBm2reg), .WBwn(WBwn),
        .WBaluResult(WBaluResult), .WBmo(WBmo),
        .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        full;
        logic        chk_mo;
        logic        wreg;
        logic        m2reg;
        logic [4:0]  wn;
        logic [31:0] alu;
        logic [31:0] mo;
        logic        emis;
        logic        eto;
    } wb_t;

    typedef struct {
        logic        wreg, m2reg, wmem;
        logic [4:0]  wn;
        logic [31:0] alu, di;
        logic        e_wreg, e_m2reg, e_emis;
    } vec_t;

    wb_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [4:0] wn, input logic [31:0] alu, input logic [31:0] di);
        MEMwreg = wreg; MEMm2reg = m2reg; MEMwmem = wmem;
        MEMwn = wn; MEMaluResult = alu; MEMdi = di;
        #1;
    endtask

    function automatic wb_t bubble();
        wb_t e;
        e = '{full: 1'b0, chk_mo: 1'b0, wreg: 1'b0, m2reg: 1'b0, wn: 5'd0,
              alu: 32'd0, mo: 32'd0, emis: 1'b0, eto: 1'b0};
        return e;
    endfunction

    function automatic wb_t pass(input logic wreg, input logic m2reg, input logic [4:0] wn,
                                 input logic [31:0] alu, input logic [31:0] mo,
                                 input logic chk_mo, input logic emis, input logic eto);
        wb_t e;
        e = '{full: 1'b1, chk_mo: chk_mo, wreg: wreg, m2reg: m2reg, wn: wn,
              alu: alu, mo: mo, emis: emis, eto: eto};
        return e;
    endfunction

    task automatic tick_check();
        wb_t e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("WBwreg", {31'd0, WBwreg}, {31'd0, e.wreg});
            chk("err_misalign", {31'd0, err_misalign}, {31'd0, e.emis});
            chk("err_timeout", {31'd0, err_timeout}, {31'd0, e.eto});
            if (e.full) begin
                chk("WBm2reg", {31'd0, WBm2reg}, {31'd0, e.m2reg});
                chk("WBwn", {27'd0, WBwn}, {27'd0, e.wn});
                chk("WBaluResult", WBaluResult, e.alu);
            end
            if (e.chk_mo) chk("WBmo", WBmo, e.mo);
        end
    endtask

    task automatic nop_cycle(input logic ack);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        dm_ack = ack;
        #1;
        chk("nop_stall", {31'd0, mem_stall}, 32'd0);
        chk("nop_req", {31'd0, dm_req}, 32'd0);
        exp_q.push_back(pass(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0));
        tick_check();
        dm_ack = 1'b0;
    endtask

    // ack_after < 0: never acknowledge; otherwise ack in WAIT cycle index ack_after.
    task automatic do_access(input logic we, input logic wreg, input logic [4:0] wn,
                             input logic [31:0] addr, input logic [31:0] data,
                             input int ack_after, input logic [31:0] rdata);
        int  n_wait;
        logic to;
        to     = !(ack_after >= 0 && ack_after < TO);
        n_wait = to ? TO : ack_after + 1;
        drive(wreg, ~we, we, wn, addr, data);
        chk("detect_stall", {31'd0, mem_stall}, 32'd1);
        chk("detect_req", {31'd0, dm_req}, 32'd0);
        exp_q.push_back(bubble());
        tick_check();
        for (int k = 0; k < n_wait; k++) begin
            chk("wait_req", {31'd0, dm_req}, 32'd1);
            chk("wait_stall", {31'd0, mem_stall}, 32'd1);
            chk("dm_we", {31'd0, dm_we}, {31'd0, we});
            chk("dm_addr", dm_addr, addr);
            chk("dm_wdata", dm_wdata, data);
            if (k == ack_after) begin
                dm_ack = 1'b1;
                dm_rdata = rdata;
            end
            exp_q.push_back(bubble());
            tick_check();
            dm_ack = 1'b0;
            dm_rdata = 32'h0;
        end
        chk("done_req", {31'd0, dm_req}, 32'd0);
        chk("done_stall", {31'd0, mem_stall}, 32'd0);
        exp_q.push_back(pass(to ? 1'b0 : wreg, ~we, wn, addr,
                             we ? 32'd0 : rdata, ~to, 1'b0, to));
        tick_check();
        nop_cycle(1'b0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd5,  32'h0000_1234, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 5'd7,  32'hFFFF_0001, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd9,  32'h0000_0042, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd2,  32'h0000_0081, 32'h1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 5'd31, 32'h0000_0043, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 5'd1,  32'h0000_0003, 32'h0, 1'b1, 1'b0, 1'b0};

        clrn = 1'b0;
        dm_ack = 1'b0;
        dm_rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rst_WBwreg", {31'd0, WBwreg}, 32'd0);
        chk("rst_WBaluResult", WBaluResult, 32'd0);
        chk("rst_WBmo", WBmo, 32'd0);
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].wreg, vecs[i].m2reg, vecs[i].wmem, vecs[i].wn, vecs[i].alu, vecs[i].di);
            chk("vec_stall", {31'd0, mem_stall}, 32'd0);
            chk("vec_req", {31'd0, dm_req}, 32'd0);
            exp_q.push_back(pass(vecs[i].e_wreg, vecs[i].e_m2reg, vecs[i].wn, vecs[i].alu,
                                 32'd0, 1'b1, vecs[i].e_emis, 1'b0));
            tick_check();
        end
        nop_cycle(1'b1);

        do_access(1'b0, 1'b1, 5'd3, 32'h0000_0040, 32'h0, 0, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 5'd4, 32'h0000_0080, 32'hCAFE_F00D, 4, 32'h55AA_55AA);
        do_access(1'b0, 1'b1, 5'd6, 32'h0000_0100, 32'h0, -1, 32'h0);
        do_access(1'b0, 1'b1, 5'd8, 32'h0000_0104, 32'h0, TO - 1, 32'h1357_9BDF);
        do_access(1'b1, 1'b1, 5'd10, 32'h0000_0200, 32'h0BAD_F00D, 1, 32'h0);

        // Reset in the third WAIT cycle, then a stray ack must be ignored.
        drive(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0300, 32'h0);
        exp_q.push_back(bubble());
        tick_check();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(bubble());
            tick_check();
        end
        chk("w3_req", {31'd0, dm_req}, 32'd1);
        clrn = 1'b0;
        #1;
        chk("arst_req", {31'd0, dm_req}, 32'd0);
        chk("arst_stall", {31'd0, mem_stall}, 32'd0);
        chk("arst_WBwn", {27'd0, WBwn}, 32'd0);
        chk("arst_WBaluResult", WBaluResult, 32'd0);
        chk("arst_WBm2reg", {31'd0, WBm2reg}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        clrn = 1'b1;
        nop_cycle(1'b1);
        nop_cycle(1'b0);
        drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0);
        chk("post_stall", {31'd0, mem_stall}, 32'd0);
        exp_q.push_back(pass(1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'd0, 1'b1, 1'b0, 1'b0));
        tick_check();
        do_access(1'b0, 1'b1, 5'd13, 32'h0000_0044, 32'h0, 2, 32'h2468_ACE0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
